vx_fetch_ooo: RTL and testbench

Instruction-fetch front end placed between the warp scheduler and the icache. It supersedes the in-order, global-squash fetch unit. Each in-flight request gets a slot in an ID-indexed metadata table, so icache responses may return in any order. Flush is per issue slot: a flush kills only that slot's in-flight requests, and requests for other slots keep flowing with no global stall.

---
 rtl/vx_fetch_ooo.sv | 224 ++++++++++++++++++++++
 tb/tb_vx_fetch_ooo.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_fetch_ooo.sv
// vx_fetch_ooo: out-of-order instruction-fetch front end between the warp
// scheduler and the icache.
//
// Every accepted scheduler request takes a free entry of an ID-indexed
// metadata table. The entry id travels to the icache in the low bits of the
// request tag, and the uuid travels in the high bits. Responses can therefore
// return in any order: the echoed id looks up pc/tmask/wid combinationally.
// A flush is per issue slot (slot = wid % ISSUE_CNT). It marks that slot's
// in-flight entries as killed, and their responses are later consumed and
// counted without being forwarded. Other slots are not stalled.
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   sched_*                       scheduler request (valid/ready, pc, tmask, wid, uuid)
//   icache_req_*                  icache request (word address, {uuid, id} tag)
//   icache_rsp_*                  icache response (instruction word, echoed tag)
//   fetch_*                       live instruction plus its metadata, to the ibuffer
//   flush[ISSUE_CNT]              per-slot kill pulse
//   ibuf_pop[ISSUE_CNT]           per-slot ibuffer pop (returns pending credit)
//   outstanding                   number of allocated table entries
//   dropped_cnt                   wrapping count of squashed responses

// Per-slot ibuffer credit counter. A flush zeroes it and overrides
// same-cycle inc/dec. A pop at zero is ignored.
module vx_fetch_ooo_pend #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)                               cnt_d = '0;
    else if (inc_i && !dec_i)                  cnt_d = cnt_q + CNT_W'(1);
    else if (dec_i && !inc_i && cnt_q != '0)   cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  assign cnt_o = cnt_q;

  a_pop_nonzero: assert property (@(posedge clk) disable iff (reset)
    (dec_i && !inc_i && !flush_i) |-> (cnt_q != '0));
endmodule

module vx_fetch_ooo #(
  parameter int NUM_WARPS   = 4,
  parameter int ISSUE_CNT   = (NUM_WARPS < 4) ? NUM_WARPS : 4,
  parameter int NUM_THREADS = 4,
  parameter int XLEN        = 32,
  parameter int UUID_W      = 44,
  parameter int DEPTH       = 8,
  parameter int IBUF_SIZE   = 4,
  parameter int ADDR_W      = 30,
  parameter int WID_W       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int ID_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sched_valid,
  output logic                     sched_ready,
  input  logic [XLEN-1:0]          sched_pc,
  input  logic [NUM_THREADS-1:0]   sched_tmask,
  input  logic [WID_W-1:0]         sched_wid,
  input  logic [UUID_W-1:0]        sched_uuid,
  output logic                     icache_req_valid,
  input  logic                     icache_req_ready,
  output logic [ADDR_W-1:0]        icache_req_addr,
  output logic [UUID_W+ID_W-1:0]   icache_req_tag,
  input  logic                     icache_rsp_valid,
  output logic                     icache_rsp_ready,
  input  logic [31:0]              icache_rsp_data,
  input  logic [UUID_W+ID_W-1:0]   icache_rsp_tag,
  output logic                     fetch_valid,
  input  logic                     fetch_ready,
  output logic [XLEN-1:0]          fetch_pc,
  output logic [NUM_THREADS-1:0]   fetch_tmask,
  output logic [WID_W-1:0]         fetch_wid,
  output logic [UUID_W-1:0]        fetch_uuid,
  output logic [31:0]              fetch_instr,
  input  logic [ISSUE_CNT-1:0]     flush,
  input  logic [ISSUE_CNT-1:0]     ibuf_pop,
  output logic [ID_W:0]            outstanding,
  output logic [31:0]              dropped_cnt
);
  localparam int SLOT_W = (ISSUE_CNT > 1) ? $clog2(ISSUE_CNT) : 1;
  localparam int CNT_W  = $clog2(IBUF_SIZE + 1);
  localparam int OUT_W  = ID_W + 1;

  function automatic logic [SLOT_W-1:0] slot_of(input logic [WID_W-1:0] w);
    return SLOT_W'(int'(w) % ISSUE_CNT);
  endfunction

  // Table: control bits are reset, metadata is only meaningful when valid.
  logic [DEPTH-1:0]                  valid_q, valid_d, killed_q, killed_d;
  logic [DEPTH-1:0][XLEN-1:0]        pc_q;
  logic [DEPTH-1:0][NUM_THREADS-1:0] tmask_q;
  logic [DEPTH-1:0][WID_W-1:0]       wid_q;
  logic [OUT_W-1:0]                  out_q, out_d;
  logic [31:0]                       drop_q, drop_d;

  logic [ISSUE_CNT-1:0][CNT_W-1:0]   pend;
  logic [ISSUE_CNT-1:0]              pend_inc;

  logic              free_found;
  logic [ID_W-1:0]   free_id;
  logic [SLOT_W-1:0] sched_slot;
  logic              can_issue, alloc;
  logic [ID_W-1:0]   rsp_id;
  logic              live, rsp_fire, rsp_free, rsp_drop;
  logic [DEPTH-1:0]  flush_hit;

  // Lowest-index free entry.
  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_id    = ID_W'(i);
      end
    end
  end

  assign sched_slot       = slot_of(sched_wid);
  assign can_issue        = free_found && (pend[sched_slot] < CNT_W'(IBUF_SIZE))
                            && !flush[sched_slot];
  assign sched_ready      = icache_req_ready && can_issue;
  assign icache_req_valid = sched_valid && can_issue;
  assign alloc            = sched_valid && sched_ready;
  assign icache_req_addr  = sched_pc[ADDR_W+1:2];
  assign icache_req_tag   = {sched_uuid, free_id};

  // Response lookup. Killed entries drain without waiting on the ibuffer.
  assign rsp_id           = icache_rsp_tag[ID_W-1:0];
  assign live             = valid_q[rsp_id] && !killed_q[rsp_id];
  assign fetch_valid      = icache_rsp_valid && live;
  assign icache_rsp_ready = !live || fetch_ready;
  assign rsp_fire         = icache_rsp_valid && icache_rsp_ready;
  assign rsp_free         = rsp_fire && valid_q[rsp_id];
  assign rsp_drop         = rsp_free && killed_q[rsp_id];

  assign fetch_pc    = pc_q[rsp_id];
  assign fetch_tmask = tmask_q[rsp_id];
  assign fetch_wid   = wid_q[rsp_id];
  assign fetch_uuid  = icache_rsp_tag[UUID_W+ID_W-1:ID_W];
  assign fetch_instr = icache_rsp_data;

  // Kill only entries that are still in flight for the flushed slot.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      flush_hit[i] = valid_q[i] && flush[slot_of(wid_q[i])];
  end

  always_comb begin
    valid_d  = valid_q;
    killed_d = killed_q | flush_hit;
    if (rsp_free) valid_d[rsp_id] = 1'b0;
    if (alloc) begin
      valid_d[free_id]  = 1'b1;
      killed_d[free_id] = 1'b0;
    end
    out_d = out_q;
    if (alloc && !rsp_free)      out_d = out_q + OUT_W'(1);
    else if (!alloc && rsp_free) out_d = out_q - OUT_W'(1);
    drop_d = rsp_drop ? drop_q + 32'd1 : drop_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      killed_q <= '0;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      killed_q <= killed_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_q[free_id]    <= sched_pc;
      tmask_q[free_id] <= sched_tmask;
      wid_q[free_id]   <= sched_wid;
    end
  end

  always_comb begin
    pend_inc = '0;
    if (alloc) pend_inc[sched_slot] = 1'b1;
  end

  for (genvar s = 0; s < ISSUE_CNT; s++) begin : g_pend
    vx_fetch_ooo_pend #(.CNT_W(CNT_W)) u_pend (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (pend_inc[s]),
      .dec_i   (ibuf_pop[s]),
      .flush_i (flush[s]),
      .cnt_o   (pend[s])
    );
  end

  assign outstanding = out_q;
  assign dropped_cnt = drop_q;

  // The pc byte offset is not part of the icache word address.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^sched_pc[1:0];

  a_rsp_allocated: assert property (@(posedge clk) disable iff (reset)
    icache_rsp_valid |-> valid_q[rsp_id]);
endmodule

// File: tb/tb_vx_fetch_ooo.sv
module tb_vx_fetch_ooo;
  localparam int NW = 4, IC = 4, NT = 4, XL = 32, UW = 44, DEPTH = 8, IB = 4, AW = 30;
  localparam int WW = 2, IW = 3, TW = UW + IW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          sched_valid, sched_ready;
  logic [XL-1:0] sched_pc;
  logic [NT-1:0] sched_tmask;
  logic [WW-1:0] sched_wid;
  logic [UW-1:0] sched_uuid;
  logic          icache_req_valid, icache_req_ready;
  logic [AW-1:0] icache_req_addr;
  logic [TW-1:0] icache_req_tag;
  logic          icache_rsp_valid, icache_rsp_ready;
  logic [31:0]   icache_rsp_data;
  logic [TW-1:0] icache_rsp_tag;
  logic          fetch_valid, fetch_ready;
  logic [XL-1:0] fetch_pc;
  logic [NT-1:0] fetch_tmask;
  logic [WW-1:0] fetch_wid;
  logic [UW-1:0] fetch_uuid;
  logic [31:0]   fetch_instr;
  logic [IC-1:0] flush, ibuf_pop;
  logic [IW:0]   outstanding;
  logic [31:0]   dropped_cnt;

  vx_fetch_ooo #(.NUM_WARPS(NW), .ISSUE_CNT(IC), .NUM_THREADS(NT), .XLEN(XL), .UUID_W(UW),
                 .DEPTH(DEPTH), .IBUF_SIZE(IB), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .sched_valid(sched_valid), .sched_ready(sched_ready), .sched_pc(sched_pc),
    .sched_tmask(sched_tmask), .sched_wid(sched_wid), .sched_uuid(sched_uuid),
    .icache_req_valid(icache_req_valid), .icache_req_ready(icache_req_ready),
    .icache_req_addr(icache_req_addr), .icache_req_tag(icache_req_tag),
    .icache_rsp_valid(icache_rsp_valid), .icache_rsp_ready(icache_rsp_ready),
    .icache_rsp_data(icache_rsp_data), .icache_rsp_tag(icache_rsp_tag),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
    .fetch_tmask(fetch_tmask), .fetch_wid(fetch_wid), .fetch_uuid(fetch_uuid),
    .fetch_instr(fetch_instr), .flush(flush), .ibuf_pop(ibuf_pop),
    .outstanding(outstanding), .dropped_cnt(dropped_cnt)
  );

  int checks = 0, errors = 0;

  // Reference model: a set of in-flight requests plus per-slot credit counts.
  bit            m_valid[DEPTH], m_killed[DEPTH];
  logic [XL-1:0] m_pc[DEPTH];
  logic [NT-1:0] m_tm[DEPTH];
  logic [UW-1:0] m_uuid[DEPTH];
  int            m_wid[DEPTH];
  int            m_pend[IC];
  int            m_out, m_drop;

  function automatic void m_reset();
    for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 0; m_killed[i] = 0; end
    for (int s = 0; s < IC; s++) m_pend[s] = 0;
    m_out = 0; m_drop = 0;
  endfunction

  function automatic int m_free_id();
    for (int i = 0; i < DEPTH; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic bit m_can_issue(int w);
    int s = w % IC;
    return (m_free_id() >= 0) && (m_pend[s] < IB) && !flush[s];
  endfunction

  function automatic bit m_live(int id);
    return m_valid[id] && !m_killed[id];
  endfunction

  // Advance one clock and apply the same cycle's events to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) m_reset();
    else begin
      int e, rid, sw;
      bit sf, rf;
      sw  = int'(sched_wid);
      sf  = sched_valid && icache_req_ready && m_can_issue(sw);
      e   = m_free_id();
      rid = int'(icache_rsp_tag[IW-1:0]);
      rf  = icache_rsp_valid && (!m_live(rid) || fetch_ready);
      if (rf && m_valid[rid]) begin
        if (m_killed[rid]) m_drop++;
        m_valid[rid] = 0;
        m_out--;
      end
      for (int i = 0; i < DEPTH; i++)
        if (m_valid[i] && flush[m_wid[i] % IC]) m_killed[i] = 1;
      for (int s = 0; s < IC; s++) begin
        if (flush[s]) m_pend[s] = 0;
        else begin
          bit inc = sf && (sw % IC == s);
          if (inc && !ibuf_pop[s]) m_pend[s]++;
          else if (!inc && ibuf_pop[s] && m_pend[s] > 0) m_pend[s]--;
        end
      end
      if (sf) begin
        m_valid[e] = 1; m_killed[e] = 0;
        m_pc[e] = sched_pc; m_tm[e] = sched_tmask; m_wid[e] = sw; m_uuid[e] = sched_uuid;
        m_out++;
      end
    end
    #1;
  endtask

  task automatic idle();
    sched_valid = 0; icache_req_ready = 0; icache_rsp_valid = 0; fetch_ready = 0;
    flush = '0; ibuf_pop = '0;
    icache_rsp_tag = '0; icache_rsp_data = '0;
  endtask

  task automatic drive_req(int w, logic [XL-1:0] pc, logic [NT-1:0] tm);
    sched_valid = 1; icache_req_ready = 1;
    sched_wid = WW'(w); sched_pc = pc; sched_tmask = tm;
    sched_uuid = UW'({$urandom, $urandom});
  endtask

  task automatic drive_rsp(int id, bit fr);
    icache_rsp_valid = 1;
    icache_rsp_tag = {m_uuid[id], IW'(id)};
    icache_rsp_data = $urandom;
    fetch_ready = fr;
  endtask

  task automatic drain();
    while (m_out > 0) begin
      idle();
      drive_rsp(m_free_id() == 0 ? 0 : 0, 1);
      for (int i = 0; i < DEPTH; i++) if (m_valid[i]) begin drive_rsp(i, 1); break; end
      tick();
    end
    idle();
  endtask

  task automatic pop_pend();
    bit any;
    do begin
      idle();
      any = 0;
      for (int s = 0; s < IC; s++) if (m_pend[s] > 0) begin ibuf_pop[s] = 1; any = 1; end
      if (any) tick();
    end while (any);
    idle();
  endtask

  task automatic test_reset();
    reset = 1; idle();
    sched_wid = '0; sched_pc = '0; sched_tmask = '0; sched_uuid = '0;
    #2;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid got %0b exp 0", fetch_valid); end
    checks++; if (icache_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %0b exp 0", icache_req_valid); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
    checks++; if (dropped_cnt !== 32'd0) begin errors++; $display("FAIL reset_dropped got %0d exp 0", dropped_cnt); end
    repeat (2) tick();
    reset = 0;
  endtask

  task automatic test_single();
    logic [UW-1:0] u;
    logic [31:0] d;
    drive_req(0, 32'h8000_0000, 4'b1111);
    u = sched_uuid;
    #1;
    checks++; if (sched_ready !== 1'b1) begin errors++; $display("FAIL single_sched_ready got %0b exp 1", sched_ready); end
    checks++; if (icache_req_addr !== 30'h2000_0000) begin errors++; $display("FAIL single_addr got %h exp 20000000", icache_req_addr); end
    checks++; if (icache_req_tag !== {u, 3'd0}) begin errors++; $display("FAIL single_tag got %h exp %h", icache_req_tag, {u, 3'd0}); end
    tick(); idle();
    repeat (3) tick();
    drive_rsp(0, 1);
    d = icache_rsp_data;
    #1;
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL single_fetch_valid got %0b exp 1", fetch_valid); end
    checks++; if (fetch_pc !== 32'h8000_0000) begin errors++; $display("FAIL single_pc got %h exp 80000000", fetch_pc); end
    checks++; if (fetch_tmask !== 4'b1111 || fetch_wid !== 2'd0) begin errors++; $display("FAIL single_meta got %b/%0d exp 1111/0", fetch_tmask, fetch_wid); end
    checks++; if (fetch_uuid !== u || fetch_instr !== d) begin errors++; $display("FAIL single_uuid_instr got %h/%h exp %h/%h", fetch_uuid, fetch_instr, u, d); end
    tick(); idle(); #1;
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL single_out_after got %0d exp 0", outstanding); end
    pop_pend();
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive_req(i % 4, $urandom, NT'($urandom));
      #1;
      checks++; if (sched_ready !== 1'b1 || icache_req_tag[IW-1:0] !== IW'(i)) begin
        errors++; $display("FAIL full_alloc_%0d got rdy %0b id %0d exp rdy 1 id %0d", i, sched_ready, icache_req_tag[IW-1:0], i); end
      tick();
    end
    drive_req(0, $urandom, 4'hf); #1;
    checks++; if (sched_ready !== 1'b0 || icache_req_valid !== 1'b0) begin errors++; $display("FAIL full_ninth got rdy %0b vld %0b exp 0 0", sched_ready, icache_req_valid); end
    checks++; if (outstanding !== 4'd8) begin errors++; $display("FAIL full_outstanding got %0d exp 8", outstanding); end
    sched_valid = 0;
    drive_rsp(5, 1); #1;
    checks++; if (fetch_valid !== 1'b1 || fetch_pc !== m_pc[5]) begin errors++; $display("FAIL full_rsp5 got %0b %h exp 1 %h", fetch_valid, fetch_pc, m_pc[5]); end
    tick(); idle();
    drive_req(1, $urandom, 4'h3); #1;
    checks++; if (sched_ready !== 1'b1 || icache_req_tag[IW-1:0] !== 3'd5) begin errors++; $display("FAIL full_reuse5 got rdy %0b id %0d exp 1 5", sched_ready, icache_req_tag[IW-1:0]); end
    tick(); idle();
    drain(); pop_pend();
  endtask

  task automatic test_ooo();
    int order[3] = '{2, 0, 1};
    for (int i = 0; i < 3; i++) begin drive_req(i, $urandom, NT'($urandom)); tick(); end
    idle();
    foreach (order[k]) begin
      drive_rsp(order[k], 1); #1;
      checks++; if (fetch_valid !== 1'b1 || fetch_pc !== m_pc[order[k]] || fetch_wid !== WW'(order[k])
                    || fetch_uuid !== m_uuid[order[k]]) begin
        errors++; $display("FAIL ooo_id%0d got %0b pc %h wid %0d exp 1 pc %h wid %0d", order[k], fetch_valid, fetch_pc, fetch_wid, m_pc[order[k]], order[k]); end
      tick(); idle();
    end
    pop_pend();
  endtask

  task automatic test_flush();
    int base = m_drop;
    drive_req(1, $urandom, 4'hf); tick();
    drive_req(2, $urandom, 4'hf); tick();
    drive_req(1, $urandom, 4'hf); flush = 4'b0010; #1;
    checks++; if (sched_ready !== 1'b0) begin errors++; $display("FAIL flush_block_alloc got %0b exp 0", sched_ready); end
    tick(); idle();
    drive_rsp(0, 0); #1;
    checks++; if (fetch_valid !== 1'b0 || icache_rsp_ready !== 1'b1) begin errors++; $display("FAIL flush_killed_rsp got fv %0b rr %0b exp 0 1", fetch_valid, icache_rsp_ready); end
    tick(); idle(); #1;
    checks++; if (dropped_cnt !== 32'(base + 1)) begin errors++; $display("FAIL flush_dropped got %0d exp %0d", dropped_cnt, base + 1); end
    drive_rsp(1, 0); #1;
    checks++; if (fetch_valid !== 1'b1 || icache_rsp_ready !== 1'b0 || fetch_wid !== 2'd2) begin
      errors++; $display("FAIL flush_other_slot got fv %0b rr %0b wid %0d exp 1 0 2", fetch_valid, icache_rsp_ready, fetch_wid); end
    fetch_ready = 1; tick(); idle(); #1;
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL flush_out got %0d exp 0", outstanding); end
    pop_pend();
  endtask

  task automatic test_ibuf();
    int base = m_drop;
    for (int k = 0; k < IB; k++) begin
      drive_req(0, $urandom, 4'h1); #1;
      checks++; if (sched_ready !== 1'b1) begin errors++; $display("FAIL ibuf_fire_%0d got %0b exp 1", k, sched_ready); end
      tick();
    end
    drive_req(0, $urandom, 4'h1); #1;
    checks++; if (sched_ready !== 1'b0 || icache_req_valid !== 1'b0) begin errors++; $display("FAIL ibuf_full got %0b %0b exp 0 0", sched_ready, icache_req_valid); end
    idle(); ibuf_pop = 4'b0001; tick();
    drive_req(0, $urandom, 4'h1); #1;
    checks++; if (sched_ready !== 1'b1) begin errors++; $display("FAIL ibuf_after_pop got %0b exp 1", sched_ready); end
    tick(); idle();
    flush = 4'b0001; tick(); idle();
    drive_req(0, $urandom, 4'h1); #1;
    checks++; if (sched_ready !== 1'b1) begin errors++; $display("FAIL ibuf_after_flush got %0b exp 1", sched_ready); end
    tick(); idle();
    drain(); #1;
    checks++; if (dropped_cnt !== 32'(base + 5)) begin errors++; $display("FAIL ibuf_dropped got %0d exp %0d", dropped_cnt, base + 5); end
    pop_pend();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin drive_req(i, $urandom, 4'hf); tick(); end
    idle(); #1;
    checks++; if (outstanding !== 4'd3) begin errors++; $display("FAIL mid_pre_out got %0d exp 3", outstanding); end
    reset = 1; drive_rsp(0, 1); #1;
    checks++; if (outstanding !== 4'd0 || dropped_cnt !== 32'd0) begin errors++; $display("FAIL mid_reset_cnt got %0d %0d exp 0 0", outstanding, dropped_cnt); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_rsp got %0b exp 0", fetch_valid); end
    tick(); idle(); reset = 0;
    drive_req(3, $urandom, 4'hf); #1;
    checks++; if (sched_ready !== 1'b1 || icache_req_tag[IW-1:0] !== 3'd0) begin errors++; $display("FAIL mid_table_empty got %0b id %0d exp 1 0", sched_ready, icache_req_tag[IW-1:0]); end
    tick(); idle(); drain(); pop_pend();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bit erv, esr, efv, err;
      int rid, cnt, pick;
      idle();
      sched_valid = $urandom_range(0, 1) == 1;
      sched_wid = WW'($urandom); sched_pc = $urandom; sched_tmask = NT'($urandom);
      sched_uuid = UW'({$urandom, $urandom});
      icache_req_ready = $urandom_range(0, 3) != 0;
      icache_rsp_tag = {UW'({$urandom, $urandom}), IW'($urandom)};
      if (m_out > 0 && $urandom_range(0, 1) == 1) begin
        pick = $urandom_range(0, m_out - 1); cnt = 0;
        for (int i = 0; i < DEPTH; i++)
          if (m_valid[i]) begin if (cnt == pick) drive_rsp(i, 0); cnt++; end
      end
      fetch_ready = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) flush = IC'($urandom);
      for (int s = 0; s < IC; s++) ibuf_pop[s] = (m_pend[s] > 0) && ($urandom_range(0, 2) == 0);
      #1;
      esr = icache_req_ready && m_can_issue(int'(sched_wid));
      erv = sched_valid && m_can_issue(int'(sched_wid));
      rid = int'(icache_rsp_tag[IW-1:0]);
      efv = icache_rsp_valid && m_live(rid);
      err = !m_live(rid) || fetch_ready;
      checks++; if (sched_ready !== esr || icache_req_valid !== erv) begin
        errors++; $display("FAIL rnd_req c%0d got rdy %0b vld %0b exp %0b %0b", c, sched_ready, icache_req_valid, esr, erv); end
      if (erv) begin
        checks++; if (icache_req_tag !== {sched_uuid, IW'(m_free_id())}) begin
          errors++; $display("FAIL rnd_tag c%0d got %h exp id %0d", c, icache_req_tag, m_free_id()); end
      end
      checks++; if (fetch_valid !== efv || icache_rsp_ready !== err) begin
        errors++; $display("FAIL rnd_rsp c%0d got fv %0b rr %0b exp %0b %0b", c, fetch_valid, icache_rsp_ready, efv, err); end
      if (efv) begin
        checks++; if (fetch_pc !== m_pc[rid] || fetch_wid !== WW'(m_wid[rid]) || fetch_tmask !== m_tm[rid]) begin
          errors++; $display("FAIL rnd_meta c%0d got %h/%0d/%b exp %h/%0d/%b", c, fetch_pc, fetch_wid, fetch_tmask, m_pc[rid], m_wid[rid], m_tm[rid]); end
      end
      checks++; if (outstanding !== (IW+1)'(m_out) || dropped_cnt !== 32'(m_drop)) begin
        errors++; $display("FAIL rnd_cnt c%0d got %0d/%0d exp %0d/%0d", c, outstanding, dropped_cnt, m_out, m_drop); end
      tick();
    end
    idle(); drain(); pop_pend(); #1;
    checks++; if (outstanding !== 4'd0 || dropped_cnt !== 32'(m_drop)) begin
      errors++; $display("FAIL rnd_final got %0d/%0d exp 0/%0d", outstanding, dropped_cnt, m_drop); end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single();
    test_full();
    test_ooo();
    test_flush();
    test_ibuf();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
